// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus generator/arbiter: FSM states and ID field constants.
package bus_arb_pkg;
    typedef enum logic [1:0] {ARB, POP, PUSH} state_t;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request strictly after `last`, wrapping.
module rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [IW-1:0] gnt,
    output logic          vld
);
    int idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = 0;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(last) + k) % N;
                if (!vld && req[IW'(idx)]) begin
                    vld = 1'b1;
                    gnt = IW'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/bus_gnrtr_arbiter.sv
// Shared-bus generator: round-robin pops one packet from a device FIFO and
// delivers it by destination ID (unicast, broadcast-except-source, or drop).
module bus_gnrtr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int              pckg_sz   = 24,
    parameter int              drvrs     = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);
    localparam int IW = $clog2(drvrs);

    state_t             state;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      last;
    logic [pckg_sz-1:0] pkt;
    logic [IW-1:0]      arb_gnt;
    logic               arb_vld;

    rr_arbiter #(.N(drvrs), .IW(IW)) u_rr (
        .req  (pndng),
        .last (last),
        .en   (state == ARB),
        .gnt  (arb_gnt),
        .vld  (arb_vld)
    );

    // Destinations at or above drvrs (other than broadcast) map to no device.
    function automatic logic [drvrs-1:0] route(input logic [ID_W-1:0] dest,
                                               input logic [IW-1:0]   src);
        logic [drvrs-1:0] r;
        r = '0;
        if (dest == broadcast) begin
            r      = '1;
            r[src] = 1'b0;
        end else if (int'(dest) < drvrs) begin
            r[dest[IW-1:0]] = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB;
            grant <= '0;
            last  <= IW'(drvrs - 1);
            pkt   <= '0;
            pop   <= '0;
            push  <= '0;
        end else begin
            case (state)
                ARB: begin
                    pop  <= '0;
                    push <= '0;
                    if (arb_vld) begin
                        grant        <= arb_gnt;
                        last         <= arb_gnt;
                        pop[arb_gnt] <= 1'b1;
                        state        <= POP;
                    end
                end
                POP: begin
                    pop   <= '0;
                    pkt   <= D_pop[grant];
                    push  <= route(D_pop[grant][pckg_sz-1 -: ID_W], grant);
                    state <= PUSH;
                end
                PUSH: begin
                    push  <= '0;
                    state <= ARB;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    state <= ARB;
                end
            endcase
        end
    end

    for (genvar l = 0; l < drvrs; l++) begin : g_lane
        assign D_push[l] = pkt;
    end
endmodule

// File: tb/tb_bus_gnrtr_arbiter.sv
// Directed plus randomized checks of bus_gnrtr_arbiter against a transaction-level model.
module tb_bus_gnrtr_arbiter;
    localparam int N  = 16;
    localparam int PW = 24;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          pndng;
    logic [N-1:0][PW-1:0]  dpop;
    logic [N-1:0]          pop;
    logic [N-1:0]          push;
    logic [N-1:0][PW-1:0]  dpush;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the bus: one transfer in flight at a time
    int           m_last;
    int           m_grant;
    bit           m_active;
    int           m_age;
    logic [N-1:0] e_pop;
    logic [N-1:0] e_push;
    logic [PW-1:0] e_pkt;

    always #5 clk = ~clk;

    bus_gnrtr_arbiter #(.pckg_sz(PW), .drvrs(N), .broadcast(8'hFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (dpop),
        .pop    (pop),
        .push   (push),
        .D_push (dpush)
    );

    task automatic chk16(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] route_m(input logic [PW-1:0] p, input int src);
        int dest;
        dest = int'(p[PW-1 -: 8]);
        if (dest == 255) return 16'hFFFF & ~(16'h1 << src);
        if (dest < N)    return 16'h1 << dest;
        return '0;
    endfunction

    // One clock: update the model from the inputs seen at the edge, then compare at negedge.
    task automatic tick();
        logic [N-1:0][PW-1:0] rep;
        @(posedge clk);
        if (!reset) begin
            m_active = 0; m_last = N - 1;
            e_pop = '0; e_push = '0; e_pkt = '0;
        end else if (!m_active) begin
            e_pop = '0; e_push = '0;
            if (pndng != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (!m_active && pndng[i]) begin
                        m_active = 1; m_grant = i; m_age = 1;
                    end
                end
                m_last = m_grant;
                e_pop  = 16'h1 << m_grant;
            end
        end else if (m_age == 1) begin
            e_pop  = '0;
            e_pkt  = dpop[m_grant];
            e_push = route_m(e_pkt, m_grant);
            m_age  = 2;
        end else begin
            e_push   = '0;
            m_active = 0;
        end
        @(negedge clk);
        for (int l = 0; l < N; l++) rep[l] = e_pkt;
        chk16("pop", pop, e_pop);
        chk16("push", push, e_push);
        chkv("d_push", dpush, rep);
    endtask

    task automatic idle(input int n);
        pndng = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [N-1:0] rr_seq [4];
        rr_seq[0] = 16'h0001; rr_seq[1] = 16'h0100; rr_seq[2] = 16'h8000; rr_seq[3] = 16'h0001;

        reset = 1'b0;
        pndng = 16'hFFFF;
        for (int l = 0; l < N; l++) dpop[l] = 24'h030000 | PW'(l);

        // reset held with everything pending
        for (int i = 0; i < 3; i++) begin
            tick();
            chk16("rst_pop", pop, 16'h0);
            chk16("rst_push", push, 16'h0);
        end
        reset = 1'b1;
        tick();
        chk16("first_grant", pop, 16'h0001);
        idle(4);

        // unicast 3 -> 5
        dpop[3] = 24'h05ABCD;
        pndng = 16'h0008;
        tick();
        chk16("uni_pop", pop, 16'h0008);
        pndng = '0;
        tick();
        chk16("uni_push", push, 16'h0020);
        chkv("uni_lane5", {{(N-1)*PW{1'b0}}, dpush[5]}, {{(N-1)*PW{1'b0}}, 24'h05ABCD});
        idle(3);

        // broadcast from 2
        dpop[2] = 24'hFF1234;
        pndng = 16'h0004;
        tick();
        pndng = '0;
        tick();
        chk16("bc_push", push, 16'hFFFB);
        idle(3);

        // round-robin with three always-pending devices
        dpop[0] = 24'h010000; dpop[8] = 24'h090000; dpop[15] = 24'h0E0000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pndng = 16'h8101;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t % 3 == 0) chk16("rr_pop", pop, rr_seq[t / 3]);
            else            chk16("rr_gap", pop, 16'h0);
        end
        idle(3);

        // out-of-range destination is dropped
        dpop[1] = 24'h200000;
        pndng = 16'h0002;
        tick();
        chk16("bad_pop", pop, 16'h0002);
        pndng = '0;
        tick();
        chk16("bad_push", push, 16'h0);
        tick();
        chk16("bad_push2", push, 16'h0);
        idle(2);

        // reset during PUSH aborts the delivery
        dpop[4] = 24'h040001;
        pndng = 16'h0010;
        tick();
        chk16("mid_pop", pop, 16'h0010);
        pndng = '0;
        tick();
        chk16("mid_push", push, 16'h0010);
        reset = 1'b0;
        tick();
        chk16("mid_rst_push", push, 16'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk16("mid_after_push", push, 16'h0);
        end

        // randomized traffic with occasional resets
        for (int t = 0; t < 400; t++) begin
            reset = ($urandom_range(0, 49) != 0);
            pndng = N'($urandom & $urandom);
            for (int l = 0; l < N; l++) begin
                int r;
                logic [7:0] d;
                r = $urandom_range(0, 3);
                if (r == 0)      d = 8'hFF;
                else if (r == 3) d = 8'($urandom_range(16, 254));
                else             d = 8'($urandom_range(0, 15));
                dpop[l] = {d, 16'($urandom)};
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_gnrtr_arbiter.md
Name: bus_gnrtr_arbiter

Overview:
- Shared-bus generator and arbiter connecting `drvrs` devices, each fronted by its own FIFO.
- Polls the devices' pending flags and grants round-robin.
- Pops one packet from the granted device's FIFO.
- Routes that packet by its 8-bit destination ID to one device FIFO, or to every other device on broadcast.
- Sits between the per-device FIFO/driver layer and the bus interface in the bus testbench environment.

Parameters:
- pckg_sz, 24, total packet width in bits; bits [pckg_sz-1 -: 8] = destination ID, the rest = payload.
- drvrs, 16, number of devices on the bus; legal range 2..255.
- broadcast, 8'hFF, destination ID meaning "deliver to all devices except the source".

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- pndng  input  drvrs  bit i = device i FIFO is non-empty.
- D_pop  input  drvrs*pckg_sz  lane i = head packet of device i FIFO (show-ahead: valid whenever pndng[i]=1).
- pop  output  drvrs  one-hot; bit i = dequeue device i FIFO this cycle.
- push  output  drvrs  bit i = enqueue D_push lane i into device i FIFO this cycle.
- D_push  output  drvrs*pckg_sz  packet offered to each device; all lanes carry the same packet.

Behaviour:
- State machine states: ARB, POP, PUSH; registers: state, grant index, last-grant pointer, packet register.
- Reset (reset=0 at a rising edge):
  - state=ARB, pop=0, push=0, D_push=0.
  - last-grant pointer = drvrs-1, so device 0 has first priority.
- ARB:
  - pop=0, push=0.
  - If pndng==0, stay in ARB.
  - Otherwise select the first i with pndng[i]=1, searching from last+1 upward and wrapping modulo drvrs.
  - Register grant=i and last=i; go to POP.
- POP (exactly 1 cycle):
  - pop[grant]=1, all other pop bits 0.
  - Capture D_pop lane `grant` into the packet register at the end of the cycle; go to PUSH.
- PUSH (exactly 1 cycle):
  - D_push = packet register on every lane; it holds its value until the next capture.
  - Let dest = packet[pckg_sz-1 -: 8].
  - If dest==broadcast: push = all ones except bit `grant`.
  - Else if dest<drvrs: push = one-hot at dest. This includes dest==grant (self-delivery is allowed).
  - Else: push=0 and the packet is silently dropped.
  - Go to ARB.
- Throughput and latency:
  - At most one packet per 3 cycles.
  - Latency from the ARB decision to push is 2 edges.
- pop and push are never asserted in the same cycle.
- pndng is ignored outside ARB.
- If pndng[grant] deasserts in POP, the pop is still issued; protecting against underflow is the FIFO's responsibility.
- Reset asserted mid-transfer aborts it: the packet is lost, and no push or pop occurs on the reset cycle or the cycle after.
- The payload is passed through unmodified, including the ID byte.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (ARB, POP, PUSH);
  - the ID field width constant (8);
  - the default broadcast ID.
- One sub-module, rr_arbiter:
  - inputs: request vector, last pointer, enable;
  - outputs: grant index, valid;
  - purely combinational wrap-around priority search.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with pndng=16'hFFFF -> pop=0, push=0, D_push=0 throughout; after release, the first grant is device 0.
- Unicast: pndng[3]=1, D_pop[3]=24'h05_ABCD -> pop[3] pulses for 1 cycle, then push=16'h0020 with D_push lane 5 = 24'h05ABCD on the next cycle.
- Broadcast: pndng[2]=1, D_pop[2]=24'hFF_1234 -> push=16'hFFFB for 1 cycle, and every lane carries 24'hFF1234.
- Round-robin fairness: pndng=16'h8101, with each FIFO continuously refilled:
  - grants are 0, 8, 15, 0, 8, ...;
  - consecutive pops are exactly 3 cycles apart.
- Invalid destination: D_pop[1]=24'h20_0000 (dest 32 ≥ 16) -> pop[1] pulses, push stays 0, and the FSM returns to ARB.
- Mid-transfer reset: assert reset=0 during PUSH of the packet 24'h04_0001 -> push drops to 0 on the next edge and the packet is not delivered after reset release.
